router_out_arbiter: RTL
=======================

# router_out_arbiter

Round-robin arbiter and output register for one router output port. It shares a single AXI-stream output among NUM_INPUTS requesting input FIFOs: the four mesh directions plus the local network interface. Each request is a single-beat routed message that route computation has already steered to this output. One instance sits in front of each router output, so the router instantiates NUM_PORTS+1 copies.

## Interface
Parameters:
- NUM_INPUTS, 5, number of requesters (NUM_PORTS mesh inputs + local port); index 0 is local.
- PORT_WIDTH, 128, message/beat width in bits.
- CNT_WIDTH, 16, width of sent-message counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_INPUTS  per-input request; head message of input i targets this output.
- req_data  in  NUM_INPUTS*PORT_WIDTH  head messages; input i occupies bits [i*PORT_WIDTH +: PORT_WIDTH].
- req_ready  out  NUM_INPUTS  one-hot pop strobe to the granted input FIFO.
- out_tvalid  out  1  AXI-stream valid toward the link/NI.
- out_tdata  out  PORT_WIDTH  AXI-stream data.
- out_tready  in  1  AXI-stream ready from the downstream.
- grant_idx  out  $clog2(NUM_INPUTS)  index of the input whose message is currently held in the output register.
- sent_count  out  CNT_WIDTH  number of completed output handshakes.

## Operation
- Two-state FSM on the output register: EMPTY (out_tvalid=0) and FULL (out_tvalid=1).
- load = (state==EMPTY) || (out_tvalid && out_tready). A new winner may be accepted only when load=1.
- Round-robin pointer rr_ptr:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_INPUTS.
  - On accept of winner w: rr_ptr <= (w+1) mod NUM_INPUTS.
  - rr_ptr is unchanged when nothing is accepted.
- req_ready[w]=1 combinationally in a cycle where load=1 and at least one req_valid is set; it is 0 otherwise. At most one bit is ever set.
- On accept: out_tdata <= req_data slice w, grant_idx <= w, state <= FULL.
- FSM transitions:
  - FULL with handshake and no request: state <= EMPTY, out_tdata holds its last value.
  - FULL without handshake: out_tdata and grant_idx are frozen (AXI stability).
- sent_count increments on every out_tvalid && out_tready and wraps from all-ones to 0.
- Requesters must hold req_valid and req_data until they see req_ready. The arbiter never depends on req_valid being deasserted without a pop.
- A req_valid with no pop is not lost: it is re-evaluated every cycle.
- Starvation bound: a continuously asserted request is granted within NUM_INPUTS accepts.

## Timing
- Reset (rst=1 at a clk edge): state=EMPTY, out_tvalid=0, out_tdata=0, grant_idx=0, rr_ptr=0, sent_count=0. req_ready=0 for the whole time rst is high.
- Reset mid-operation: any held message is discarded without a handshake, and sent_count does not count it.
- Latency: req_valid rises in cycle t with state EMPTY -> req_ready in cycle t, out_tvalid=1 from cycle t+1.
- Throughput: with out_tready held at 1, one message per cycle is sustained. A handshake and an accept in the same cycle keep out_tvalid=1 continuously.
- Backpressure: out_tready=0 while FULL -> req_ready stays all zeros and no pointer change.
- Wrap-around: rr_ptr after grant of index NUM_INPUTS-1 is 0.
- All outputs except req_ready are registered. req_ready depends combinationally on req_valid, state and out_tready.

## Test plan
- Reset check: assert rst for 3 cycles with all req_valid=5'b11111 -> req_ready=0, out_tvalid=0, out_tdata=0, sent_count=0 throughout.
- Single requester: req_valid=5'b00010, data 128'hA5 on input 1, out_tready=1 -> req_ready=5'b00010 in cycle 0; out_tdata=128'hA5, grant_idx=1, out_tvalid=1 in cycle 1; sent_count=1 after handshake.
- Fairness: all 5 inputs request continuously, out_tready=1, data = input index -> output sequence 0,1,2,3,4,0,1,… one per cycle; each input gets exactly 2 grants in 10 cycles.
- Backpressure: inputs 2 and 3 request, out_tready=0 for 4 cycles after first accept -> out_tdata (input 2's value) and grant_idx=2 stable, req_ready=0 for those 4 cycles; when out_tready=1, input 3 is accepted in the same cycle.
- Pointer wrap and skip: rr_ptr=4 after grant of input 3, req_valid=5'b00101 -> input 0 wins, then input 2, then input 0.
- Counter wrap with CNT_WIDTH=4: 17 handshakes -> sent_count reads 0 after the 16th and 1 after the 17th; mid-transfer rst with out_tvalid=1 -> out_tvalid=0 next cycle and no count.

Source files
------------

// File: rtl/router_out_arbiter.sv
// ---------------------------------------------------------------------------
// router_out_arbiter
// Round-robin arbiter plus output register for one router output port. Picks
// one of NUM_INPUTS single-beat head messages, pops it from its input FIFO and
// presents it on an AXI-stream output held stable until the downstream accepts.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   req_valid   per-input request (head message targets this output)
//   req_data    head messages, input i at [i*PORT_WIDTH +: PORT_WIDTH]
//   req_ready   one-hot pop strobe to the granted input (combinational)
//   out_tvalid  AXI-stream valid (registered)
//   out_tdata   AXI-stream data (registered)
//   out_tready  AXI-stream ready from downstream
//   grant_idx   input index of the message in the output register
//   sent_count  completed output handshakes, wraps
// ---------------------------------------------------------------------------
module router_out_arbiter #(
    parameter int unsigned NUM_INPUTS = 5,
    parameter int unsigned PORT_WIDTH = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            req_valid,
    input  logic [NUM_INPUTS*PORT_WIDTH-1:0] req_data,
    output logic [NUM_INPUTS-1:0]            req_ready,
    output logic                             out_tvalid,
    output logic [PORT_WIDTH-1:0]            out_tdata,
    input  logic                             out_tready,
    output logic [$clog2(NUM_INPUTS)-1:0]    grant_idx,
    output logic [CNT_WIDTH-1:0]             sent_count
);

    localparam int unsigned IDX_W = $clog2(NUM_INPUTS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                state_q,  state_d;
    logic [PORT_WIDTH-1:0] tdata_q,  tdata_d;
    logic [IDX_W-1:0]      grant_q,  grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      win_next;
    logic [PORT_WIDTH-1:0] win_data;
    logic                  handshake;
    logic                  load;

    // Rotating-priority search starting at rr_ptr; the candidate index is one
    // bit wider so rr_ptr + k can be folded back without a modulo operator.
    always_comb begin : p_winner
        logic [IDX_W:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_INPUTS)) begin
                cand = cand - (IDX_W+1)'(NUM_INPUTS);
            end
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Pointer moves to the input just after the winner.
    always_comb begin : p_next_ptr
        if (win_idx == IDX_W'(NUM_INPUTS - 1)) begin
            win_next = '0;
        end else begin
            win_next = win_idx + IDX_W'(1);
        end
    end

    // Winner's data slice.
    always_comb begin : p_win_data
        win_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = req_data[i*PORT_WIDTH +: PORT_WIDTH];
            end
        end
    end

    // Next-state and pop strobe. The register can take a new message when it
    // is empty or is being drained this cycle; reset masks the pop so no
    // FIFO loses a message to a register that is about to be cleared.
    always_comb begin : p_fsm
        state_d   = state_q;
        tdata_d   = tdata_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        req_ready = '0;

        handshake = (state_q == FULL) && out_tready;
        load      = (state_q == EMPTY) || handshake;

        if (handshake) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            EMPTY: begin
                if (win_found) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (handshake && !win_found) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (load && win_found && !rst) begin
            req_ready[win_idx] = 1'b1;
            tdata_d            = win_data;
            grant_d            = win_idx;
            rr_ptr_d           = win_next;
        end
    end

    // State register; reset discards any held message without counting it.
    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            state_q  <= EMPTY;
            tdata_q  <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_tvalid = (state_q == FULL);
    assign out_tdata  = tdata_q;
    assign grant_idx  = grant_q;
    assign sent_count = cnt_q;

endmodule
